// File: rtl/fir_avmm_pkg.sv
// Shared types and defaults for the FIR Avalon-MM port arbiter.
package fir_avmm_pkg;

  localparam int DEF_NUM_REQ      = 4;
  localparam int DEF_ADDR_W       = 64;
  localparam int DEF_DATA_W       = 64;
  localparam int DEF_READ_LATENCY = 2;

  localparam int MAX_REQ  = 16;
  localparam int REQ_ID_W = $clog2(MAX_REQ);

  typedef logic [REQ_ID_W-1:0] req_id_t;

  // Index of the set bit of a one-hot vector (zero when no bit is set).
  function automatic req_id_t onehot_to_idx(input logic [MAX_REQ-1:0] onehot);
    req_id_t idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (onehot[i]) begin
        idx = idx | req_id_t'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/fir_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts after the last winner.
module fir_rr_arbiter
  import fir_avmm_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output req_id_t            grant_id
);

  req_id_t            ptr_reg;
  logic [MAX_REQ-1:0] grant_wide;
  logic               found;

  // Pick the first requester at or after ptr+1, wrapping; none while in reset.
  always_comb begin
    grant = '0;
    found = 1'b0;
    if (resetn) begin
      for (int off = 1; off <= NUM_REQ; off++) begin
        for (int j = 0; j < NUM_REQ; j++) begin
          if (!found && req[j] && (j == (int'(ptr_reg) + off) % NUM_REQ)) begin
            grant[j] = 1'b1;
            found    = 1'b1;
          end
        end
      end
    end
    grant_wide              = '0;
    grant_wide[NUM_REQ-1:0] = grant;
    grant_id                = onehot_to_idx(grant_wide);
  end

  // The last winner becomes lowest priority; reset favours requester 0.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ptr_reg <= req_id_t'(NUM_REQ - 1);
    end else if (|grant) begin
      ptr_reg <= grant_id;
    end
  end

endmodule

// File: rtl/fir_avmm_arbiter.sv
// Shares one fixed-latency Avalon-MM master among NUM_REQ requesters.
module fir_avmm_arbiter
  import fir_avmm_pkg::*;
#(
  parameter int NUM_REQ      = DEF_NUM_REQ,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int READ_LATENCY = DEF_READ_LATENCY
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_address,
  input  logic [NUM_REQ*(DATA_W/8)-1:0] req_byteenable,
  input  logic [NUM_REQ-1:0]            req_read,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*DATA_W-1:0]     req_writedata,
  output logic [NUM_REQ-1:0]            req_waitrequest,
  output logic [DATA_W-1:0]             req_readdata,
  output logic [NUM_REQ-1:0]            req_readdatavalid,
  output logic [ADDR_W-1:0]             avmm_rw_address,
  output logic [(DATA_W/8)-1:0]         avmm_rw_byteenable,
  output logic                          avmm_rw_read,
  output logic                          avmm_rw_write,
  output logic [DATA_W-1:0]             avmm_rw_writedata,
  input  logic [DATA_W-1:0]             avmm_rw_readdata,
  output logic                          protocol_err
);

  localparam int BE_W = DATA_W / 8;

  logic [NUM_REQ-1:0] grant;
  req_id_t            grant_id;
  logic [ADDR_W-1:0]  sel_address;
  logic [BE_W-1:0]    sel_byteenable;
  logic [DATA_W-1:0]  sel_writedata;
  logic               sel_read;
  logic               sel_write;
  logic               sel_conflict;

  logic [ADDR_W-1:0]  address_reg;
  logic [BE_W-1:0]    byteenable_reg;
  logic [DATA_W-1:0]  writedata_reg;
  logic               read_reg;
  logic               write_reg;
  logic               protocol_err_reg;
  req_id_t            issue_id_reg;

  logic               pipe_valid_reg [READ_LATENCY];
  req_id_t            pipe_id_reg    [READ_LATENCY];

  fir_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clock    (clock),
    .resetn   (resetn),
    .req      (req_read | req_write),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign req_waitrequest = ~grant;

  // One-hot mux of the granted requester's command; read wins a read/write clash.
  always_comb begin
    sel_address    = '0;
    sel_byteenable = '0;
    sel_writedata  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_address    = req_address[i*ADDR_W +: ADDR_W];
        sel_byteenable = req_byteenable[i*BE_W +: BE_W];
        sel_writedata  = req_writedata[i*DATA_W +: DATA_W];
      end
    end
    sel_read     = |(grant & req_read);
    sel_write    = |(grant & req_write & ~req_read);
    sel_conflict = |(grant & req_read & req_write);
  end

  // Output command register; payload holds when nothing is granted.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      address_reg      <= '0;
      byteenable_reg   <= '0;
      writedata_reg    <= '0;
      read_reg         <= 1'b0;
      write_reg        <= 1'b0;
      protocol_err_reg <= 1'b0;
      issue_id_reg     <= '0;
    end else begin
      read_reg  <= sel_read;
      write_reg <= sel_write;
      if (|grant) begin
        address_reg    <= sel_address;
        byteenable_reg <= sel_byteenable;
        writedata_reg  <= sel_writedata;
        issue_id_reg   <= grant_id;
      end
      if (sel_conflict) begin
        protocol_err_reg <= 1'b1;
      end
    end
  end

  assign avmm_rw_address    = address_reg;
  assign avmm_rw_byteenable = byteenable_reg;
  assign avmm_rw_writedata  = writedata_reg;
  assign avmm_rw_read       = read_reg;
  assign avmm_rw_write      = write_reg;
  assign protocol_err       = protocol_err_reg;

  // ID pipeline matched to memory latency, fed by the issued read strobe.
  for (genvar gi = 0; gi < READ_LATENCY; gi++) begin : g_stage
    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        pipe_valid_reg[gi] <= 1'b0;
        pipe_id_reg[gi]    <= '0;
      end else if (gi == 0) begin
        pipe_valid_reg[gi] <= read_reg;
        pipe_id_reg[gi]    <= issue_id_reg;
      end else begin
        pipe_valid_reg[gi] <= pipe_valid_reg[gi-1];
        pipe_id_reg[gi]    <= pipe_id_reg[gi-1];
      end
    end
  end

  // Steer the tap's valid to the owning requester; data is broadcast.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rdv
    assign req_readdatavalid[gi] = pipe_valid_reg[READ_LATENCY-1] &&
                                   (pipe_id_reg[READ_LATENCY-1] == req_id_t'(gi));
  end

  assign req_readdata = avmm_rw_readdata;

endmodule

// File: tb/tb_fir_avmm_arbiter.sv
// Randomized bench for fir_avmm_arbiter against a transaction-level model.
module tb_fir_avmm_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 64;
  localparam int DATA_W  = 64;
  localparam int BE_W    = DATA_W / 8;
  localparam int LAT     = 2;

  logic                        clock;
  logic                        resetn;
  logic [NUM_REQ*ADDR_W-1:0]   req_address;
  logic [NUM_REQ*BE_W-1:0]     req_byteenable;
  logic [NUM_REQ-1:0]          req_read;
  logic [NUM_REQ-1:0]          req_write;
  logic [NUM_REQ*DATA_W-1:0]   req_writedata;
  logic [NUM_REQ-1:0]          req_waitrequest;
  logic [DATA_W-1:0]           req_readdata;
  logic [NUM_REQ-1:0]          req_readdatavalid;
  logic [ADDR_W-1:0]           avmm_rw_address;
  logic [BE_W-1:0]             avmm_rw_byteenable;
  logic                        avmm_rw_read;
  logic                        avmm_rw_write;
  logic [DATA_W-1:0]           avmm_rw_writedata;
  logic [DATA_W-1:0]           avmm_rw_readdata;
  logic                        protocol_err;

  fir_avmm_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .READ_LATENCY (LAT)
  ) dut (
    .clock              (clock),
    .resetn             (resetn),
    .req_address        (req_address),
    .req_byteenable     (req_byteenable),
    .req_read           (req_read),
    .req_write          (req_write),
    .req_writedata      (req_writedata),
    .req_waitrequest    (req_waitrequest),
    .req_readdata       (req_readdata),
    .req_readdatavalid  (req_readdatavalid),
    .avmm_rw_address    (avmm_rw_address),
    .avmm_rw_byteenable (avmm_rw_byteenable),
    .avmm_rw_read       (avmm_rw_read),
    .avmm_rw_write      (avmm_rw_write),
    .avmm_rw_writedata  (avmm_rw_writedata),
    .avmm_rw_readdata   (avmm_rw_readdata),
    .protocol_err       (protocol_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Requester-side command state (held until accepted).
  logic [NUM_REQ-1:0] r_rd, r_wr;
  logic [63:0]        r_addr [NUM_REQ];
  logic [7:0]         r_be   [NUM_REQ];
  logic [63:0]        r_wd   [NUM_REQ];
  logic [NUM_REQ-1:0] auto_mask;
  int                 auto_kind;   // 0 read, 1 write, 2 random

  // Reference model: last winner, expected port contents, expected returns.
  typedef struct {
    int          due;
    int          id;
    logic [63:0] data;
  } pend_t;
  pend_t       pend [$];
  int          m_ptr;
  logic        m_read, m_write, m_perr;
  logic [63:0] m_addr, m_wd;
  logic [7:0]  m_be;
  int          cyc;

  // Memory model: returns address+1 LAT cycles after a read strobe.
  logic        hist_rd [16];
  logic [63:0] hist_ad [16];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d: got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic arm(input int i, input logic rd, input logic wr, input logic [63:0] addr);
    r_rd[i]   = rd;
    r_wr[i]   = wr;
    r_addr[i] = addr;
    r_be[i]   = 8'($urandom);
    r_wd[i]   = {$urandom, $urandom};
  endtask

  task automatic model_clear();
    m_ptr   = NUM_REQ - 1;
    m_read  = 1'b0;
    m_write = 1'b0;
    m_perr  = 1'b0;
    m_addr  = '0;
    m_wd    = '0;
    m_be    = '0;
    pend.delete();
  endtask

  task automatic check_reset_values();
    logic [NUM_REQ-1:0] all_wait;
    all_wait = '1;
    check("rst_waitrequest", 64'(req_waitrequest), 64'(all_wait));
    check("rst_read", 64'(avmm_rw_read), 64'd0);
    check("rst_write", 64'(avmm_rw_write), 64'd0);
    check("rst_address", avmm_rw_address, 64'd0);
    check("rst_byteenable", 64'(avmm_rw_byteenable), 64'd0);
    check("rst_writedata", avmm_rw_writedata, 64'd0);
    check("rst_readdatavalid", 64'(req_readdatavalid), 64'd0);
    check("rst_protocol_err", 64'(protocol_err), 64'd0);
  endtask

  // One clock cycle: drive, compare against the model, advance the model.
  task automatic step();
    int                 g;
    int                 pc;
    logic [NUM_REQ-1:0] exp_grant;
    logic [NUM_REQ-1:0] exp_wait;
    logic [NUM_REQ-1:0] exp_rdv;
    logic [63:0]        exp_rdata;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (auto_mask[i] && !r_rd[i] && !r_wr[i]) begin
        if (auto_kind == 0) arm(i, 1'b1, 1'b0, {$urandom, $urandom});
        else if (auto_kind == 1) arm(i, 1'b0, 1'b1, {$urandom, $urandom});
        else if ($urandom_range(1) == 1) begin
          if ($urandom_range(1) == 1) arm(i, 1'b1, 1'b0, {$urandom, $urandom});
          else arm(i, 1'b0, 1'b1, {$urandom, $urandom});
        end
      end
      req_read[i]                         = r_rd[i];
      req_write[i]                        = r_wr[i];
      req_address[i*ADDR_W +: ADDR_W]     = r_addr[i];
      req_byteenable[i*BE_W +: BE_W]      = r_be[i];
      req_writedata[i*DATA_W +: DATA_W]   = r_wd[i];
    end
    pc = cyc - LAT;
    if (pc >= 0 && hist_rd[pc % 16]) avmm_rw_readdata = hist_ad[pc % 16] + 64'd1;
    else avmm_rw_readdata = {$urandom, $urandom};
    #1;
    g = -1;
    for (int off = 1; off <= NUM_REQ; off++) begin
      int j;
      j = (m_ptr + off) % NUM_REQ;
      if (g < 0 && (r_rd[j] || r_wr[j])) g = j;
    end
    exp_grant = '0;
    if (g >= 0) exp_grant[g] = 1'b1;
    exp_wait = ~exp_grant;
    check("waitrequest", 64'(req_waitrequest), 64'(exp_wait));
    check("avmm_read", 64'(avmm_rw_read), 64'(m_read));
    check("avmm_write", 64'(avmm_rw_write), 64'(m_write));
    check("avmm_address", avmm_rw_address, m_addr);
    check("avmm_byteenable", 64'(avmm_rw_byteenable), 64'(m_be));
    check("avmm_writedata", avmm_rw_writedata, m_wd);
    exp_rdv   = '0;
    exp_rdata = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      exp_rdv[pend[0].id] = 1'b1;
      exp_rdata           = pend[0].data;
      void'(pend.pop_front());
    end
    check("readdatavalid", 64'(req_readdatavalid), 64'(exp_rdv));
    if (exp_rdv != '0) check("readdata", req_readdata, exp_rdata);
    check("protocol_err", 64'(protocol_err), 64'(m_perr));
    if (g >= 0) begin
      m_ptr   = g;
      m_read  = r_rd[g];
      m_write = r_wr[g] & ~r_rd[g];
      m_addr  = r_addr[g];
      m_be    = r_be[g];
      m_wd    = r_wd[g];
      if (r_rd[g] && r_wr[g]) m_perr = 1'b1;
      if (r_rd[g]) pend.push_back('{due: cyc + 1 + LAT, id: g, data: r_addr[g] + 64'd1});
      $display("txn cyc=%0d req=%0d %s addr=%h", cyc, g,
               r_rd[g] ? (r_wr[g] ? "rd+wr" : "read") : "write", r_addr[g]);
      r_rd[g] = 1'b0;
      r_wr[g] = 1'b0;
    end else begin
      m_read  = 1'b0;
      m_write = 1'b0;
    end
    hist_rd[cyc % 16] = avmm_rw_read;
    hist_ad[cyc % 16] = avmm_rw_address;
    cyc++;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Asynchronous reset pulse in the middle of a cycle with traffic pending.
  task automatic reset_pulse();
    #2;
    resetn = 1'b0;
    #1;
    check_reset_values();
    @(posedge clock);
    @(negedge clock);
    resetn = 1'b1;
    model_clear();
    hist_rd[cyc % 16] = 1'b0;
    cyc++;
    r_rd      = '0;
    r_wr      = '0;
    auto_mask = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn         = 1'b0;
    req_address    = '0;
    req_byteenable = '0;
    req_read       = '0;
    req_write      = '0;
    req_writedata  = '0;
    avmm_rw_readdata = '0;
    r_rd      = '0;
    r_wr      = '0;
    auto_mask = '0;
    auto_kind = 0;
    cyc       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      r_addr[i] = '0;
      r_be[i]   = '0;
      r_wd[i]   = '0;
    end
    for (int i = 0; i < 16; i++) begin
      hist_rd[i] = 1'b0;
      hist_ad[i] = '0;
    end
    model_clear();
    @(negedge clock);
    @(negedge clock);
    #1;
    check_reset_values();
    @(negedge clock);
    resetn = 1'b1;

    // All four requesters hold writes: rotation 0,1,2,3,...
    auto_kind = 1; auto_mask = '1;
    run(12);
    auto_mask = '0;
    run(6);

    // Requester 0 alone: three back-to-back reads.
    arm(0, 1'b1, 1'b0, 64'h100); step();
    arm(0, 1'b1, 1'b0, 64'h108); step();
    arm(0, 1'b1, 1'b0, 64'h110); step();
    run(6);

    // Requesters 1 and 3 read continuously.
    auto_kind = 0; auto_mask = 4'b1010;
    run(10);
    auto_mask = '0;
    run(6);

    // Mixed random traffic.
    auto_kind = 2; auto_mask = '1;
    run(200);
    auto_mask = '0;
    run(8);

    // Read/write clash from requester 2, then more traffic.
    arm(2, 1'b1, 1'b1, 64'h40); step();
    run(3);
    auto_mask = '1;
    run(100);
    auto_mask = '0;
    run(8);

    // Two reads in flight, then reset; pre-reset reads must not return.
    arm(1, 1'b1, 1'b0, 64'h200); step();
    arm(3, 1'b1, 1'b0, 64'h300); step();
    reset_pulse();
    for (int i = NUM_REQ - 1; i >= 0; i--) arm(i, 1'b1, 1'b0, {$urandom, $urandom});
    run(12);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
